frost_share_arbiter: RTL and testbench
======================================

Name: frost_share_arbiter

Overview:
- Time-multiplexes one shared scalar bus for DKG share distribution between 4 FROST nodes, replacing the 16 point-to-point share wires.
- Each source node raises a request with a destination index and share value. The block grants sources round-robin, drives each share onto the bus until the destination accepts it, and records delivery in a 16-bit matrix.
- Flags completion when all N×N (src,dst) shares are delivered, or an error when the protocol stalls.

Parameters:
- NUM_NODES, 4, number of nodes; only 4 supported (2-bit node index).
- SCALAR_BITS, 252, share width.
- TIMEOUT, 1024, idle-cycle limit before stall error (must be < 2^16).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  pulse; begins an exchange round from IDLE, DONE or ERR.
- req  in  4  per-source request; bit s = node s has a share pending.
- req_dst  in  8  destination of source s at bits [2s+1:2s].
- req_data  in  4*SCALAR_BITS  share of source s at bits [s*SCALAR_BITS +: SCALAR_BITS].
- rx_ready  in  4  per-destination accept; bit d = node d can take a share this cycle.
- grant  out  4  one-hot, 1-cycle pulse; request of source s consumed.
- bus_valid  out  1  bus holds a share.
- bus_src  out  2  source of the bus share.
- bus_dst  out  2  destination of the bus share.
- bus_data  out  SCALAR_BITS  share value.
- delivered_mask  out  16  bit d*4+s set once share src s → dst d is delivered.
- all_delivered  out  1  high in DONE.
- timeout_err  out  1  high in ERR.
- busy  out  1  high in ARB or XFER.

Behaviour:
- Reset: state IDLE, rr_ptr=0, timer=0. All outputs 0 (grant, bus_valid, bus_src, bus_dst, bus_data, delivered_mask, all_delivered, timeout_err, busy). Reset mid-transfer aborts immediately; no partial state is retained.
- States: IDLE, ARB, XFER, DONE, ERR. All outputs are registered.
- IDLE/DONE/ERR + start → ARB on the next edge. On that edge: delivered_mask=0, timer=0, rr_ptr=0, all_delivered=0, timeout_err=0.
- start while busy is ignored.
- ARB, eligible requests: eligible(s) = req[s] && !delivered_mask[req_dst_s*4+s]. Requests for already-delivered pairs are never granted; only the timeout ends such a stall.
- ARB, selection: pick the first eligible s scanning rr_ptr, rr_ptr+1, … mod 4.
- ARB, on a pick (next edge): grant[s]=1 for exactly one cycle; bus_valid=1; bus_src=s; bus_dst=req_dst_s; bus_data=req_data_s. The requester may change req/req_dst/req_data from the cycle after grant. Go to XFER.
- ARB, no eligible request: stay in ARB.
- XFER: bus_src/bus_dst/bus_data stay stable while bus_valid=1. The transfer completes on a cycle where rx_ready[bus_dst]=1. On that edge:
  - bus_valid=0
  - delivered_mask bit set
  - rr_ptr=bus_src+1 (mod 4)
  - timer=0
  - next state DONE if the mask becomes 16'hFFFF, else ARB.
- Self-delivery (src==dst) is legal and counts toward the mask.
- Throughput: minimum 2 cycles per share (one ARB, one XFER), so ≥32 cycles for a full round.
- Timer: increments every cycle in ARB/XFER; cleared on each completion. When timer reaches TIMEOUT-1 while in ARB/XFER → ERR on the next edge: timeout_err=1, bus_valid=0, grant=0; delivered_mask is frozen for debug.
- Simultaneous events:
  - Completion and timeout on the same cycle: completion wins and the timer clears.
  - start in DONE/ERR with req already high: the round restarts; req is evaluated from the first ARB cycle.
- DONE: all_delivered=1, bus_valid=0; holds until start or reset.
- bus_data retains its last value when bus_valid=0.

Test Plan:
- Reset, then start; each source s requests dst 0..3 in order with data s*16+d; rx_ready=4'hF → 16 grants, mask reaches 16'hFFFF, all_delivered=1 at cycle 32±1 after start, every bus_data matches.
- All 4 req high, each source dst=0, rx_ready=4'hF → grants in order 0,1,2,3; the next round starts from rr_ptr=0 after source 3.
- Source 2 → dst 1, rx_ready[1] held low 10 cycles → bus_valid high 10 cycles with stable src=2/dst=1/data; completion on the cycle rx_ready[1] rises; mask bit 6 set.
- TIMEOUT=16, source 0 re-requests the delivered pair (0→0) with no other req → no grant; timeout_err=1 exactly 16 cycles after the last completion; mask unchanged; a following start clears both.
- Assert rst_n low during XFER → all outputs 0 asynchronously; after release the block stays IDLE until start.
- start pulsed during ARB with 5 shares delivered → ignored; mask keeps 5 bits, round continues.

Source files
------------

// File: rtl/frost_share_arbiter.sv
// frost_share_arbiter
// Shares one scalar bus among four FROST nodes during DKG share
// distribution. Sources are granted round-robin, each granted share is held
// on the bus until its destination accepts it, and every delivered
// (src,dst) pair is recorded in a 16-bit matrix. The block reports DONE once
// all sixteen pairs are delivered, or ERR when no share completes within
// TIMEOUT cycles.
module frost_share_arbiter #(
  parameter int NUM_NODES   = 4,     // only 4 supported (2-bit node index)
  parameter int SCALAR_BITS = 252,
  parameter int TIMEOUT     = 1024   // must be < 2^16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [NUM_NODES-1:0]             req,
  input  logic [2*NUM_NODES-1:0]           req_dst,
  input  logic [NUM_NODES*SCALAR_BITS-1:0] req_data,
  input  logic [NUM_NODES-1:0]             rx_ready,
  output logic [NUM_NODES-1:0]             grant,
  output logic                             bus_valid,
  output logic [1:0]                       bus_src,
  output logic [1:0]                       bus_dst,
  output logic [SCALAR_BITS-1:0]           bus_data,
  output logic [NUM_NODES*NUM_NODES-1:0]   delivered_mask,
  output logic                             all_delivered,
  output logic                             timeout_err,
  output logic                             busy
);

  localparam int          MASK_W     = NUM_NODES * NUM_NODES;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_XFER,
    ST_DONE,
    ST_ERR
  } state_t;

  // Registered state and outputs
  state_t                   r_state;
  logic [1:0]               r_rr_ptr;
  logic [15:0]              r_timer;
  logic [NUM_NODES-1:0]     r_grant;
  logic                     r_bus_valid;
  logic [1:0]               r_bus_src;
  logic [1:0]               r_bus_dst;
  logic [SCALAR_BITS-1:0]   r_bus_data;
  logic [MASK_W-1:0]        r_mask;
  logic                     r_all_delivered;
  logic                     r_timeout_err;
  logic                     r_busy;

  // Next-state values
  state_t                   w_state_nxt;
  logic [1:0]               w_rr_nxt;
  logic [15:0]              w_timer_nxt;
  logic [NUM_NODES-1:0]     w_grant_nxt;
  logic                     w_valid_nxt;
  logic [1:0]               w_src_nxt;
  logic [1:0]               w_dst_nxt;
  logic [SCALAR_BITS-1:0]   w_data_nxt;
  logic [MASK_W-1:0]        w_mask_nxt;

  // Arbitration helpers
  logic [NUM_NODES-1:0]     w_elig;
  logic                     w_pick_found;
  logic [1:0]               w_pick_idx;
  logic [1:0]               w_pick_dst;
  logic [SCALAR_BITS-1:0]   w_pick_data;
  logic                     w_timeout;
  logic                     w_xfer_done;

  // First eligible source scanning ptr, ptr+1, ... (mod 4). Returns
  // {found, index}; scanning from the far end lets the nearest hit win.
  function automatic logic [2:0] f_rr_pick(input logic [3:0] elig,
                                           input logic [1:0] ptr);
    logic [1:0] idx;
    f_rr_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (elig[idx]) f_rr_pick = {1'b1, idx};
    end
  endfunction

  // A source is eligible only if its requested pair is not yet delivered
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_elig = '0;
    for (int s = 0; s < NUM_NODES; s++) begin
      w_elig[s] = req[s] && !r_mask[{req_dst[2*s +: 2], 2'(s)}];
    end
  end

  // Round-robin pick plus mux of the picked source's destination and share
  always_comb begin
    {w_pick_found, w_pick_idx} = f_rr_pick(w_elig, r_rr_ptr);
    w_pick_dst  = '0;
    w_pick_data = '0;
    for (int s = 0; s < NUM_NODES; s++) begin
      if (w_pick_idx == 2'(s)) begin
        w_pick_dst  = req_dst[2*s +: 2];
        w_pick_data = req_data[s*SCALAR_BITS +: SCALAR_BITS];
      end
    end
  end

  assign w_timeout   = (r_timer == TIMER_LAST);
  assign w_xfer_done = rx_ready[r_bus_dst];

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_timer_nxt = r_timer;
    w_grant_nxt = '0;            // grant is a single-cycle pulse
    w_valid_nxt = r_bus_valid;
    w_src_nxt   = r_bus_src;
    w_dst_nxt   = r_bus_dst;
    w_data_nxt  = r_bus_data;    // bus_data keeps its last value when idle
    w_mask_nxt  = r_mask;

    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_state_nxt = ST_ARB;
          w_mask_nxt  = '0;
          w_timer_nxt = '0;
          w_rr_nxt    = '0;
          w_valid_nxt = 1'b0;
        end
      end

      ST_ARB: begin
        w_timer_nxt = r_timer + 16'd1;
        if (w_timeout) begin
          // A pick on the timeout cycle is dropped; ERR wins in ARB.
          w_state_nxt = ST_ERR;
          w_valid_nxt = 1'b0;
        end else if (w_pick_found) begin
          w_state_nxt             = ST_XFER;
          w_grant_nxt[w_pick_idx] = 1'b1;
          w_valid_nxt             = 1'b1;
          w_src_nxt               = w_pick_idx;
          w_dst_nxt               = w_pick_dst;
          w_data_nxt              = w_pick_data;
        end
      end

      ST_XFER: begin
        if (w_xfer_done) begin
          // Completion takes priority over a coincident timeout.
          w_mask_nxt  = r_mask | (MASK_W'(1) << {r_bus_dst, r_bus_src});
          w_valid_nxt = 1'b0;
          w_rr_nxt    = r_bus_src + 2'd1;
          w_timer_nxt = '0;
          w_state_nxt = (w_mask_nxt == '1) ? ST_DONE : ST_ARB;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERR;
          w_valid_nxt = 1'b0;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register: all FSM state and every output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_rr_ptr        <= '0;
      r_timer         <= '0;
      r_grant         <= '0;
      r_bus_valid     <= 1'b0;
      r_bus_src       <= '0;
      r_bus_dst       <= '0;
      // NOTE: the wide share register is reset too, because bus_data must
      // read zero out of reset and no stale share may survive an abort.
      r_bus_data      <= '0;
      r_mask          <= '0;
      r_all_delivered <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      r_state         <= w_state_nxt;
      r_rr_ptr        <= w_rr_nxt;
      r_timer         <= w_timer_nxt;
      r_grant         <= w_grant_nxt;
      r_bus_valid     <= w_valid_nxt;
      r_bus_src       <= w_src_nxt;
      r_bus_dst       <= w_dst_nxt;
      r_bus_data      <= w_data_nxt;
      r_mask          <= w_mask_nxt;
      r_all_delivered <= (w_state_nxt == ST_DONE);
      r_timeout_err   <= (w_state_nxt == ST_ERR);
      r_busy          <= (w_state_nxt == ST_ARB) || (w_state_nxt == ST_XFER);
    end
  end

  assign grant          = r_grant;
  assign bus_valid      = r_bus_valid;
  assign bus_src        = r_bus_src;
  assign bus_dst        = r_bus_dst;
  assign bus_data       = r_bus_data;
  assign delivered_mask = r_mask;
  assign all_delivered  = r_all_delivered;
  assign timeout_err    = r_timeout_err;
  assign busy           = r_busy;

endmodule

// File: tb/tb_frost_share_arbiter.sv
// Directed bench for frost_share_arbiter with a short timeout (16 cycles).
// Expected values are hand-derived from the cycle schedule: one ARB cycle
// and one XFER cycle per share when the destination is ready.
module tb_frost_share_arbiter;

  localparam int SB = 252;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    req;
  logic [7:0]    req_dst;
  logic [4*SB-1:0] req_data;
  logic [3:0]    rx_ready;
  logic [3:0]    grant;
  logic          bus_valid;
  logic [1:0]    bus_src;
  logic [1:0]    bus_dst;
  logic [SB-1:0] bus_data;
  logic [15:0]   delivered_mask;
  logic          all_delivered;
  logic          timeout_err;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  frost_share_arbiter #(
    .NUM_NODES  (4),
    .SCALAR_BITS(SB),
    .TIMEOUT    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .req           (req),
    .req_dst       (req_dst),
    .req_data      (req_data),
    .rx_ready      (rx_ready),
    .grant         (grant),
    .bus_valid     (bus_valid),
    .bus_src       (bus_src),
    .bus_dst       (bus_dst),
    .bus_data      (bus_data),
    .delivered_mask(delivered_mask),
    .all_delivered (all_delivered),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input int d, input int data);
    req_dst[2*s +: 2]   = 2'(d);
    req_data[s*SB +: SB] = SB'(data);
    req[s]               = 1'b1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_grant"},     grant,          0);
    check({pfx, "_valid"},     bus_valid,      0);
    check({pfx, "_src"},       bus_src,        0);
    check({pfx, "_dst"},       bus_dst,        0);
    check({pfx, "_data"},      bus_data,       0);
    check({pfx, "_mask"},      delivered_mask, 0);
    check({pfx, "_all"},       all_delivered,  0);
    check({pfx, "_tmo"},       timeout_err,    0);
    check({pfx, "_busy"},      busy,           0);
  endtask

  initial begin
    logic [15:0] exp_mask;
    int          src_k;
    int          dst_k;

    rst_n    = 1'b0;
    start    = 1'b0;
    req      = '0;
    req_dst  = '0;
    req_data = '0;
    rx_ready = '0;

    // ---- reset state ----
    tick;
    tick;
    check_all_zero("rst");
    rst_n = 1'b1;
    tick;
    check("rst_idle_busy", busy, 0);

    // ---- full round: source s sends to dst 0..3 with data s*16+d ----
    rx_ready = 4'hF;
    for (int s = 0; s < 4; s++) set_req(s, 0, s * 16);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("t1_busy_after_start", busy, 1);
    exp_mask = '0;
    for (int k = 0; k < 16; k++) begin
      src_k = k % 4;
      dst_k = k / 4;
      tick;  // grant edge
      check($sformatf("t1_grant_%0d", k), grant, 4'b0001 << src_k);
      check($sformatf("t1_valid_%0d", k), bus_valid, 1);
      check($sformatf("t1_src_%0d", k),   bus_src, src_k);
      check($sformatf("t1_dst_%0d", k),   bus_dst, dst_k);
      check($sformatf("t1_data_%0d", k),  bus_data, src_k * 16 + dst_k);
      check($sformatf("t1_all_lo_%0d", k), all_delivered, 0);
      if (dst_k < 3) set_req(src_k, dst_k + 1, src_k * 16 + dst_k + 1);
      else req[src_k] = 1'b0;
      tick;  // completion edge
      exp_mask[dst_k*4 + src_k] = 1'b1;
      check($sformatf("t1_cvalid_%0d", k), bus_valid, 0);
      check($sformatf("t1_cgrant_%0d", k), grant, 0);
      check($sformatf("t1_mask_%0d", k),   delivered_mask, exp_mask);
    end
    // 32 edges after the start edge
    check("t1_all_delivered", all_delivered, 1);
    check("t1_busy_done", busy, 0);
    check("t1_mask_full", delivered_mask, 16'hFFFF);

    // ---- round-robin order: all four to dst 0, then wrap to source 0 ----
    for (int s = 0; s < 4; s++) set_req(s, 0, 'hA0 + s);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("t2_all_cleared", all_delivered, 0);
    check("t2_mask_cleared", delivered_mask, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check($sformatf("t2_grant_%0d", k), grant, 4'b0001 << k);
      check($sformatf("t2_dst_%0d", k),   bus_dst, 0);
      check($sformatf("t2_data_%0d", k),  bus_data, 'hA0 + k);
      set_req(k, 1, 'hB0 + k);
      tick;
      check($sformatf("t2_mask_%0d", k), delivered_mask, (16'd1 << (k + 1)) - 16'd1);
    end
    tick;
    check("t2_wrap_grant", grant, 4'b0001);
    check("t2_wrap_dst",   bus_dst, 1);
    check("t2_wrap_data",  bus_data, 'hB0);
    req = '0;
    tick;
    check("t2_mask5", delivered_mask, 16'h001F);

    // ---- start during ARB is ignored ----
    start = 1'b1;
    tick;
    start = 1'b0;
    check("t6_busy",  busy, 1);
    check("t6_mask",  delivered_mask, 16'h001F);
    check("t6_all",   all_delivered, 0);
    set_req(1, 1, 'hC1);
    tick;
    check("t6_grant", grant, 4'b0010);
    check("t6_src",   bus_src, 1);
    check("t6_dst",   bus_dst, 1);
    check("t6_data",  bus_data, 'hC1);
    req = '0;
    tick;
    check("t6_mask6", delivered_mask, 16'h003F);

    // ---- backpressure: source 2 -> dst 1, rx_ready[1] low 10 cycles ----
    set_req(2, 1, 'hD2);
    rx_ready = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      tick;
      check($sformatf("t3_valid_%0d", i), bus_valid, 1);
      check($sformatf("t3_src_%0d", i),   bus_src, 2);
      check($sformatf("t3_dst_%0d", i),   bus_dst, 1);
      check($sformatf("t3_data_%0d", i),  bus_data, 'hD2);
      check($sformatf("t3_grant_%0d", i), grant, (i == 0) ? 4'b0100 : 4'b0000);
      if (i == 0) begin
        // requester moves on after its grant; bus must not follow
        set_req(2, 3, 'hEE);
        req = '0;
      end
    end
    rx_ready = 4'hF;
    tick;
    check("t3_done_valid", bus_valid, 0);
    check("t3_mask_bit6",  delivered_mask[6], 1);
    check("t3_mask",       delivered_mask, 16'h007F);
    check("t3_busy",       busy, 1);

    // ---- timeout: re-request of delivered pair 0->0 only ----
    set_req(0, 0, 'h55);
    for (int i = 0; i < 15; i++) begin
      tick;
      check($sformatf("t4_grant_%0d", i), grant, 0);
      check($sformatf("t4_tmo_%0d", i),   timeout_err, 0);
    end
    tick;  // 16 cycles after the last completion
    check("t4_tmo",   timeout_err, 1);
    check("t4_busy",  busy, 0);
    check("t4_valid", bus_valid, 0);
    check("t4_grant", grant, 0);
    check("t4_mask",  delivered_mask, 16'h007F);
    req   = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("t4_restart_tmo",  timeout_err, 0);
    check("t4_restart_mask", delivered_mask, 0);
    check("t4_restart_busy", busy, 1);

    // ---- asynchronous reset during XFER ----
    set_req(3, 2, 'h77);
    tick;
    check("t5_grant3", grant, 4'b1000);
    req = '0;
    tick;
    check("t5_mask", delivered_mask, 16'h0800);
    set_req(1, 0, 'h99);
    rx_ready = 4'h0;
    tick;
    check("t5_grant1", grant, 4'b0010);
    tick;
    check("t5_xfer_valid", bus_valid, 1);
    check("t5_xfer_data",  bus_data, 'h99);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("t5_idle_busy_%0d", i),  busy, 0);
      check($sformatf("t5_idle_grant_%0d", i), grant, 0);
      check($sformatf("t5_idle_valid_%0d", i), bus_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
